iiitb_wm_plant: RTL and testbench
=================================

IIITB_WM_PLANT -- requirements
Module: iiitb_wm_plant

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4: clk cycles per plant tick, legal range 2..256.
REQ-002 SHALL have parameter FILL_TICKS, default 8: ticks to fill from empty; also the full-level value.
REQ-003 SHALL have parameter DET_TICKS, default 2: ticks for the dispenser to deliver detergent.
REQ-004 SHALL have parameter CYCLE_TICKS, default 16: motor ticks per wash cycle.
REQ-005 SHALL have parameter SPIN_TICKS, default 8: ticks of spin before spin completes.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port fill_value_on, input, 1 bit: fill valve command from the controller.
REQ-009 SHALL have port drain_value_on, input, 1 bit: drain valve command.
REQ-010 SHALL have port motor_on, input, 1 bit: drum motor command.
REQ-011 SHALL have port door_lock, input, 1 bit: door lock command.
REQ-012 SHALL have port soap_wash, input, 1 bit: soap phase flag.
REQ-013 SHALL have port water_wash, input, 1 bit: rinse phase flag.
REQ-014 SHALL have port filled, output, 1 bit: water level equals FILL_TICKS.
REQ-015 SHALL have port drained, output, 1 bit: water level equals 0.
REQ-016 SHALL have port detergent_added, output, 1 bit: dispense complete.
REQ-017 SHALL have port cycle_timeout, output, 1 bit: wash time elapsed.
REQ-018 SHALL have port spin_timeout, output, 1 bit: spin time elapsed.
REQ-019 SHALL have port level, output, 8 bits: current water level.
REQ-020 SHALL have port fault, output, 1 bit: sticky interlock fault.

Function
REQ-021 SHALL run a prescaler that counts 0..TICK_DIV-1 and wraps; tick is high in the cycle the count equals TICK_DIV-1.
REQ-022 SHALL update the level only on tick: +1 if fill_value_on=1 and drain_value_on=0; -1 if drain_value_on=1 and fill_value_on=0; hold if both or neither are 1.
REQ-023 SHALL saturate the level at FILL_TICKS and at 0; it SHALL never wrap.
REQ-024 SHALL register all outputs; filled and drained are decoded from the registered level, so they change in the cycle after the level changes.
REQ-025 SHALL raise the dispense request when soap_wash=1, filled=1, and fill, drain and motor are all 0; the detergent counter increments on tick while the request holds.
REQ-026 SHALL hold detergent_added=1 while the detergent count is at least DET_TICKS and the request holds; the counter clears and the output drops in the cycle after the request drops.
REQ-027 SHALL increment the wash counter on tick while motor_on=1 and drain_value_on=0; cycle_timeout=1 while the count is at least CYCLE_TICKS; the counter clears when motor_on=0.
REQ-028 SHALL increment the spin counter on tick while drain_value_on=1, drained=1 and water_wash=1; spin_timeout=1 while the count is at least SPIN_TICKS; the counter clears when any of those conditions drops.
REQ-029 SHALL saturate all counters at their terminal value; holding a condition indefinitely keeps the timeout at 1.
REQ-030 SHALL evaluate simultaneous events in the same cycle independently; no command has priority except the fill/drain rule in REQ-022.

Reset
REQ-031 SHALL, with reset=1 at a rising edge, clear the prescaler, level and all counters, and drive outputs level=0, drained=1, filled=0, detergent_added=0, cycle_timeout=0, spin_timeout=0, fault=0.
REQ-032 SHALL let reset asserted mid-fill or mid-spin override all activity in that cycle; the first tick occurs TICK_DIV cycles after reset is released.

Configuration
REQ-033 SHALL, with WM_PLANT_FAULT_EN defined, set fault=1 in the cycle after door_lock=0 while level>0 or motor_on=1, and hold fault until reset.
REQ-034 SHALL, without WM_PLANT_FAULT_EN, tie fault to constant 0 and include no fault logic.

Verification
REQ-035 SHALL cover: default parameters, fill_value_on=1 held from reset release -> level reaches 8 after 32 clocks, filled=1 in clock 33, level stays at 8.
REQ-036 SHALL cover: level=8, fill=0, soap_wash=1 -> detergent_added=1 after 2 ticks; drop soap_wash -> detergent_added=0 in the next cycle.
REQ-037 SHALL cover: motor_on=1 for 16 ticks -> cycle_timeout rises; motor_on=0 for 1 cycle -> counter clears and a fresh 16 ticks is needed.
REQ-038 SHALL cover: drain from level 8 with water_wash=1 -> drained=1 after 8 ticks, spin_timeout=1 after 8 more ticks; fill and drain both 1 -> level holds.
REQ-039 SHALL cover: reset pulsed at level 5 -> level=0, drained=1 and all timeouts 0 in the next cycle.
REQ-040 SHALL cover: with the macro defined, door_lock=0 at level 3 -> fault=1 and held after door_lock returns to 1; without the macro -> fault stays 0.

Source files
------------

// File: rtl/iiitb_wm_plant.sv
// Washing-machine plant model: water level, detergent dispenser, wash and spin timers.
// Latency: level moves one step per plant tick; every output is registered (flags lag the level by one clock).
// Backpressure: none; commands are sampled every clock. Optional fault interlock built with WM_PLANT_FAULT_EN.
module iiitb_wm_plant #(
    parameter int TICK_DIV    = 4,
    parameter int FILL_TICKS  = 8,
    parameter int DET_TICKS   = 2,
    parameter int CYCLE_TICKS = 16,
    parameter int SPIN_TICKS  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fill_value_on,
    input  logic       drain_value_on,
    input  logic       motor_on,
    input  logic       door_lock,
    input  logic       soap_wash,
    input  logic       water_wash,
    output logic       filled,
    output logic       drained,
    output logic       detergent_added,
    output logic       cycle_timeout,
    output logic       spin_timeout,
    output logic [7:0] level,
    output logic       fault
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DET_TICKS + 1);
    localparam int CW = $clog2(CYCLE_TICKS + 1);
    localparam int SW = $clog2(SPIN_TICKS + 1);

    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [7:0]    FILL_MAX = 8'(FILL_TICKS);
    localparam logic [DW-1:0] DET_MAX  = DW'(DET_TICKS);
    localparam logic [CW-1:0] CYC_MAX  = CW'(CYCLE_TICKS);
    localparam logic [SW-1:0] SPIN_MAX = SW'(SPIN_TICKS);

    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [7:0]    level_next;
    logic          det_req;
    logic          spin_cond;
    logic [DW-1:0] det_cnt,  det_next;
    logic [CW-1:0] wash_cnt, wash_next;
    logic [SW-1:0] spin_cnt, spin_next;

    assign tick      = (pre_cnt == PRE_MAX);
    // Dispensing only happens with a full, idle drum during the soap phase.
    assign det_req   = soap_wash & filled & ~fill_value_on & ~drain_value_on & ~motor_on;
    assign spin_cond = drain_value_on & drained & water_wash;

    // Prescaler: free-running 0..TICK_DIV-1, tick on the terminal count.
    always_ff @(posedge clk) begin
        if (reset) pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else pre_cnt <= pre_cnt + 1'b1;
    end

    // Next-state for level and the three saturating counters.
    always_comb begin
        level_next = level;
        if (tick) begin
            if (fill_value_on && !drain_value_on && level != FILL_MAX)
                level_next = level + 8'd1;
            else if (drain_value_on && !fill_value_on && level != 8'd0)
                level_next = level - 8'd1;
        end

        det_next = det_cnt;
        if (!det_req) det_next = '0;
        else if (tick && det_cnt != DET_MAX) det_next = det_cnt + 1'b1;

        wash_next = wash_cnt;
        if (!motor_on) wash_next = '0;
        else if (tick && !drain_value_on && wash_cnt != CYC_MAX) wash_next = wash_cnt + 1'b1;

        spin_next = spin_cnt;
        if (!spin_cond) spin_next = '0;
        else if (tick && spin_cnt != SPIN_MAX) spin_next = spin_cnt + 1'b1;
    end

    // Level register; filled/drained decode the current registered level so they lag it by a clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            level   <= 8'd0;
            filled  <= 1'b0;
            drained <= 1'b1;
        end else begin
            level   <= level_next;
            filled  <= (level == FILL_MAX);
            drained <= (level == 8'd0);
        end
    end

    // Counters and their timeout flags, flags reflect the counter value being loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            det_cnt         <= '0;
            wash_cnt        <= '0;
            spin_cnt        <= '0;
            detergent_added <= 1'b0;
            cycle_timeout   <= 1'b0;
            spin_timeout    <= 1'b0;
        end else begin
            det_cnt         <= det_next;
            wash_cnt        <= wash_next;
            spin_cnt        <= spin_next;
            detergent_added <= det_req && (det_next == DET_MAX);
            cycle_timeout   <= (wash_next == CYC_MAX);
            spin_timeout    <= (spin_next == SPIN_MAX);
        end
    end

`ifdef WM_PLANT_FAULT_EN
    // Sticky interlock: door unlocked with water in the drum or the motor running.
    always_ff @(posedge clk) begin
        if (reset) fault <= 1'b0;
        else if (!door_lock && (level != 8'd0 || motor_on)) fault <= 1'b1;
    end
`else
    logic unused_door_lock;
    assign unused_door_lock = door_lock;
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_iiitb_wm_plant.sv
module tb_iiitb_wm_plant;

    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       fill_value_on, drain_value_on, motor_on, door_lock, soap_wash, water_wash;
    logic       filled, drained, detergent_added, cycle_timeout, spin_timeout, fault;
    logic [7:0] level;

    int vectors    = 0;
    int miscompares = 0;
    int edges      = 0;
    logic exp_fault;

    always #5 clk = ~clk;

    iiitb_wm_plant dut (
        .clk(clk), .reset(reset),
        .fill_value_on(fill_value_on), .drain_value_on(drain_value_on),
        .motor_on(motor_on), .door_lock(door_lock),
        .soap_wash(soap_wash), .water_wash(water_wash),
        .filled(filled), .drained(drained), .detergent_added(detergent_added),
        .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout),
        .level(level), .fault(fault)
    );

    // Advance n rising edges; land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        edges = edges + n;
    endtask

    // Step until the bench-side edge count sits just after a tick.
    task automatic align();
        while (edges % TDIV != 0) step(1);
    endtask

    task automatic test_reset();
        reset = 1'b1; fill_value_on = 0; drain_value_on = 0; motor_on = 0;
        door_lock = 1'b1; soap_wash = 0; water_wash = 0;
        step(2);
        vectors++; if (level !== 8'd0) begin miscompares++; $display("FAIL rst_level got %0d want 0", level); end
        vectors++; if (drained !== 1'b1 || filled !== 1'b0) begin miscompares++; $display("FAIL rst_flags drained=%b filled=%b want 1/0", drained, filled); end
        vectors++; if ({detergent_added, cycle_timeout, spin_timeout, fault} !== 4'b0) begin miscompares++; $display("FAIL rst_timeouts got %b want 0000", {detergent_added, cycle_timeout, spin_timeout, fault}); end
    endtask

    task automatic test_fill();
        reset = 1'b0; fill_value_on = 1'b1; edges = 0;
        step(4);
        vectors++; if (level !== 8'd1 || drained !== 1'b1) begin miscompares++; $display("FAIL fill_first level=%0d drained=%b want 1/1", level, drained); end
        step(1);
        vectors++; if (drained !== 1'b0) begin miscompares++; $display("FAIL fill_drained_drop got %b want 0", drained); end
        step(27);
        vectors++; if (level !== 8'd8 || filled !== 1'b0) begin miscompares++; $display("FAIL fill_32 level=%0d filled=%b want 8/0", level, filled); end
        step(1);
        vectors++; if (filled !== 1'b1) begin miscompares++; $display("FAIL fill_33 filled=%b want 1", filled); end
        step(8);
        vectors++; if (level !== 8'd8) begin miscompares++; $display("FAIL fill_sat level=%0d want 8", level); end
    endtask

    task automatic test_detergent();
        align();
        fill_value_on = 1'b0; soap_wash = 1'b1;
        step(7);
        vectors++; if (detergent_added !== 1'b0) begin miscompares++; $display("FAIL det_early got %b want 0", detergent_added); end
        step(1);
        vectors++; if (detergent_added !== 1'b1) begin miscompares++; $display("FAIL det_done got %b want 1", detergent_added); end
        step(8);
        vectors++; if (detergent_added !== 1'b1) begin miscompares++; $display("FAIL det_hold got %b want 1", detergent_added); end
        soap_wash = 1'b0;
        step(1);
        vectors++; if (detergent_added !== 1'b0) begin miscompares++; $display("FAIL det_drop got %b want 0", detergent_added); end
    endtask

    task automatic test_cycle();
        align();
        motor_on = 1'b1;
        step(63);
        vectors++; if (cycle_timeout !== 1'b0) begin miscompares++; $display("FAIL cyc_early got %b want 0", cycle_timeout); end
        step(1);
        vectors++; if (cycle_timeout !== 1'b1) begin miscompares++; $display("FAIL cyc_done got %b want 1", cycle_timeout); end
        step(8);
        vectors++; if (cycle_timeout !== 1'b1) begin miscompares++; $display("FAIL cyc_sat got %b want 1", cycle_timeout); end
        motor_on = 1'b0;
        step(1);
        vectors++; if (cycle_timeout !== 1'b0) begin miscompares++; $display("FAIL cyc_clear got %b want 0", cycle_timeout); end
        align();
        motor_on = 1'b1;
        step(63);
        vectors++; if (cycle_timeout !== 1'b0) begin miscompares++; $display("FAIL cyc_fresh_early got %b want 0", cycle_timeout); end
        step(1);
        vectors++; if (cycle_timeout !== 1'b1) begin miscompares++; $display("FAIL cyc_fresh_done got %b want 1", cycle_timeout); end
        motor_on = 1'b0;
        vectors++; if (level !== 8'd8) begin miscompares++; $display("FAIL cyc_level level=%0d want 8", level); end
    endtask

    task automatic test_drain_spin();
        align();
        drain_value_on = 1'b1; water_wash = 1'b1;
        step(32);
        vectors++; if (level !== 8'd0 || drained !== 1'b0) begin miscompares++; $display("FAIL drain_32 level=%0d drained=%b want 0/0", level, drained); end
        step(1);
        vectors++; if (drained !== 1'b1) begin miscompares++; $display("FAIL drain_33 drained=%b want 1", drained); end
        step(30);
        vectors++; if (spin_timeout !== 1'b0) begin miscompares++; $display("FAIL spin_early got %b want 0", spin_timeout); end
        step(1);
        vectors++; if (spin_timeout !== 1'b1 || level !== 8'd0) begin miscompares++; $display("FAIL spin_done spin=%b level=%0d want 1/0", spin_timeout, level); end
        drain_value_on = 1'b0;
        step(1);
        vectors++; if (spin_timeout !== 1'b0) begin miscompares++; $display("FAIL spin_clear got %b want 0", spin_timeout); end
        water_wash = 1'b0;
        align();
        fill_value_on = 1'b1;
        step(12);
        vectors++; if (level !== 8'd3) begin miscompares++; $display("FAIL refill level=%0d want 3", level); end
        drain_value_on = 1'b1;
        step(8);
        vectors++; if (level !== 8'd3) begin miscompares++; $display("FAIL both_hold level=%0d want 3", level); end
        fill_value_on = 1'b0; drain_value_on = 1'b0;
    endtask

    task automatic test_fault();
`ifdef WM_PLANT_FAULT_EN
        exp_fault = 1'b1;
`else
        exp_fault = 1'b0;
`endif
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL fault_idle got %b want 0", fault); end
        door_lock = 1'b0;
        step(1);
        vectors++; if (fault !== exp_fault) begin miscompares++; $display("FAIL fault_set got %b want %b", fault, exp_fault); end
        door_lock = 1'b1;
        step(2);
        vectors++; if (fault !== exp_fault) begin miscompares++; $display("FAIL fault_sticky got %b want %b", fault, exp_fault); end
    endtask

    task automatic test_reset_mid();
        align();
        fill_value_on = 1'b1;
        step(8);
        vectors++; if (level !== 8'd5) begin miscompares++; $display("FAIL pre_rst level=%0d want 5", level); end
        reset = 1'b1;
        step(1);
        vectors++; if (level !== 8'd0 || drained !== 1'b1 || filled !== 1'b0) begin miscompares++; $display("FAIL mid_rst level=%0d drained=%b filled=%b want 0/1/0", level, drained, filled); end
        vectors++; if ({detergent_added, cycle_timeout, spin_timeout, fault} !== 4'b0) begin miscompares++; $display("FAIL mid_rst_flags got %b want 0000", {detergent_added, cycle_timeout, spin_timeout, fault}); end
        reset = 1'b0; edges = 0;
        step(3);
        vectors++; if (level !== 8'd0) begin miscompares++; $display("FAIL post_rst_3 level=%0d want 0", level); end
        step(1);
        vectors++; if (level !== 8'd1) begin miscompares++; $display("FAIL post_rst_tick level=%0d want 1", level); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_detergent();
        test_cycle();
        test_drain_spin();
        test_fault();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
